// File: rtl/sdram_arbiter_if.sv
`default_nettype none
// =============================================================================
// sdram_arbiter_if : requester-side and SRAM-side signals of the SDRAM arbiter
// Revision: 1.0
// =============================================================================
interface sdram_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic              dma_ack;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_ack;

  logic              tape_req;
  logic [ADDR_W-1:0] tape_addr;
  logic              tape_ack;

  logic              fdd_req;
  logic [ADDR_W-1:0] fdd_addr;
  logic              fdd_ack;

  logic [7:0]        rd_data;
  logic [1:0]        owner;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_rd;
  logic              mem_ready;
  logic [7:0]        mem_dout;

  modport slave (
    input  dma_req, dma_we, dma_addr, dma_din,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  tape_req, tape_addr,
    input  fdd_req, fdd_addr,
    output dma_ack, cpu_ack, tape_ack, fdd_ack,
    output rd_data, owner,
    output mem_addr, mem_din, mem_we, mem_rd,
    input  mem_ready, mem_dout
  );

  modport master (
    output dma_req, dma_we, dma_addr, dma_din,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output tape_req, tape_addr,
    output fdd_req, fdd_addr,
    input  dma_ack, cpu_ack, tape_ack, fdd_ack,
    input  rd_data, owner,
    input  mem_addr, mem_din, mem_we, mem_rd,
    output mem_ready, mem_dout
  );
endinterface
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// =============================================================================
// sdram_arbiter : registered four-way arbiter in front of the shared SDRAM byte port
// Revision: 1.0
// =============================================================================
module sdram_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk_sys,
  input  logic           nRESET,
  sdram_arbiter_if.slave bus
);

  localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_MAX_CNT  = CNT_W'(MAX_WAIT);
  localparam logic [1:0]       c_OWN_DMA  = 2'd0;
  localparam logic [1:0]       c_OWN_CPU  = 2'd1;
  localparam logic [1:0]       c_OWN_TAPE = 2'd2;
  localparam logic [1:0]       c_OWN_FDD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              we_q, we_d;
  logic [1:0]        owner_q, owner_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rr_q, rr_d;
  logic [CNT_W-1:0]  tape_cnt_q, tape_cnt_d;
  logic [CNT_W-1:0]  fdd_cnt_q, fdd_cnt_d;

  logic              w_any_req;
  logic              w_tape_prom;
  logic              w_fdd_prom;
  logic [1:0]        w_win;
  logic              w_access;
  logic              w_done;

  assign w_any_req   = bus.dma_req | bus.cpu_req | bus.tape_req | bus.fdd_req;
  assign w_tape_prom = bus.tape_req && (tape_cnt_q == c_MAX_CNT);
  assign w_fdd_prom  = bus.fdd_req && (fdd_cnt_q == c_MAX_CNT);

  // rr_q = 0 favours tape, 1 favours FDD whenever both streams tie
  always_comb begin : arbitrate
    w_win = c_OWN_DMA;
    if (bus.dma_req) begin
      w_win = c_OWN_DMA;
    end else if (w_tape_prom && w_fdd_prom) begin
      w_win = rr_q ? c_OWN_FDD : c_OWN_TAPE;
    end else if (w_tape_prom) begin
      w_win = c_OWN_TAPE;
    end else if (w_fdd_prom) begin
      w_win = c_OWN_FDD;
    end else if (bus.cpu_req) begin
      w_win = c_OWN_CPU;
    end else if (bus.tape_req && bus.fdd_req) begin
      w_win = rr_q ? c_OWN_FDD : c_OWN_TAPE;
    end else if (bus.tape_req) begin
      w_win = c_OWN_TAPE;
    end else begin
      w_win = c_OWN_FDD;
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = we_q;
    owner_d    = owner_q;
    rd_data_d  = rd_data_q;
    rr_d       = rr_q;
    tape_cnt_d = bus.tape_req ? tape_cnt_q : '0;
    fdd_cnt_d  = bus.fdd_req ? fdd_cnt_q : '0;

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          state_d = S_ACCESS;
          owner_d = w_win;
          case (w_win)
            c_OWN_DMA: begin
              addr_d = bus.dma_addr;
              din_d  = bus.dma_din;
              we_d   = bus.dma_we;
            end
            c_OWN_CPU: begin
              addr_d = bus.cpu_addr;
              din_d  = bus.cpu_din;
              we_d   = bus.cpu_we;
            end
            c_OWN_TAPE: begin
              addr_d = bus.tape_addr;
              din_d  = 8'h00;
              we_d   = 1'b0;
            end
            default: begin
              addr_d = bus.fdd_addr;
              din_d  = 8'h00;
              we_d   = 1'b0;
            end
          endcase

          if (w_win == c_OWN_TAPE || w_win == c_OWN_FDD) begin
            rr_d = ~rr_q;
          end

          // Only a CPU win counts as a lost arbitration for the streams
          if (w_win == c_OWN_TAPE) begin
            tape_cnt_d = '0;
          end else if (w_win == c_OWN_CPU && bus.tape_req && tape_cnt_q != c_MAX_CNT) begin
            tape_cnt_d = tape_cnt_q + 1'b1;
          end

          if (w_win == c_OWN_FDD) begin
            fdd_cnt_d = '0;
          end else if (w_win == c_OWN_CPU && bus.fdd_req && fdd_cnt_q != c_MAX_CNT) begin
            fdd_cnt_d = fdd_cnt_q + 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (bus.mem_ready) begin
          state_d = S_DONE;
          if (!we_q) begin
            rd_data_d = bus.mem_dout;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      din_q      <= 8'h00;
      we_q       <= 1'b0;
      owner_q    <= c_OWN_DMA;
      rd_data_q  <= 8'h00;
      rr_q       <= 1'b0;
      tape_cnt_q <= '0;
      fdd_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      rd_data_q  <= rd_data_d;
      rr_q       <= rr_d;
      tape_cnt_q <= tape_cnt_d;
      fdd_cnt_q  <= fdd_cnt_d;
    end
  end

  // Outputs are forced low for as long as nRESET is held, not only after the edge
  assign w_access = nRESET && (state_q == S_ACCESS);
  assign w_done   = nRESET && (state_q == S_DONE);

  assign bus.mem_addr = nRESET ? addr_q : '0;
  assign bus.mem_din  = nRESET ? din_q : 8'h00;
  assign bus.mem_we   = w_access && we_q;
  assign bus.mem_rd   = w_access && !we_q;

  assign bus.dma_ack  = w_done && (owner_q == c_OWN_DMA);
  assign bus.cpu_ack  = w_done && (owner_q == c_OWN_CPU);
  assign bus.tape_ack = w_done && (owner_q == c_OWN_TAPE);
  assign bus.fdd_ack  = w_done && (owner_q == c_OWN_FDD);

  assign bus.rd_data  = nRESET ? rd_data_q : 8'h00;
  assign bus.owner    = nRESET ? owner_q : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// tb_sdram_arbiter : table-driven, directed and randomized checks of sdram_arbiter
module tb_sdram_arbiter;

  localparam int ADDR_W   = 25;
  localparam int MAX_WAIT = 8;

  logic clk_sys = 1'b0;
  logic nRESET  = 1'b0;

  sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         mem_lat   = 0;
  int         lat_cnt   = 0;
  logic       rand_mem  = 1'b0;
  logic [7:0] next_dout = 8'h00;

  typedef struct {
    logic [1:0]        port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    int                lat;
    logic [7:0]        dout;
    int                exp_ack_cyc;
    logic [7:0]        exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: raises mem_ready after mem_lat extra command cycles
  task automatic mem_respond();
    if (bus.mem_rd || bus.mem_we) begin
      if (lat_cnt >= mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_dout  = next_dout;
        lat_cnt       = 0;
        if (rand_mem) begin
          mem_lat   = $urandom_range(0, 3);
          next_dout = 8'($urandom);
        end
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_dout  = 8'hEE;
        lat_cnt++;
      end
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_dout  = 8'hEE;
      lat_cnt       = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    mem_respond();
    #1;
  endtask

  task automatic drive_port(input logic [1:0] p, input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [7:0] din);
    case (p)
      2'd0: begin bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_din = din; end
      2'd1: begin bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_din = din; end
      2'd2: begin bus.tape_req = req; bus.tape_addr = addr; end
      default: begin bus.fdd_req = req; bus.fdd_addr = addr; end
    endcase
  endtask

  function automatic logic ack_of(input logic [1:0] p);
    case (p)
      2'd0:    return bus.dma_ack;
      2'd1:    return bus.cpu_ack;
      2'd2:    return bus.tape_ack;
      default: return bus.fdd_ack;
    endcase
  endfunction

  function automatic logic [3:0] acks();
    return {bus.fdd_ack, bus.tape_ack, bus.cpu_ack, bus.dma_ack};
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) drive_port(2'(p), 1'b0, 1'b0, '0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    nRESET = 1'b0;
    clear_inputs();
    repeat (n) tick();
    check("reset acks", 32'(acks()), 32'h0);
    check("reset mem_cmd", 32'({bus.mem_we, bus.mem_rd}), 32'h0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'h0);
    check("reset owner", 32'(bus.owner), 32'h0);
    check("reset rd_data", 32'(bus.rd_data), 32'h0);
    nRESET = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   ack_cyc = -1;
    int   n_ack   = 0;
    logic seen    = 1'b0;
    mem_lat   = v.lat;
    next_dout = v.dout;
    drive_port(v.port, 1'b1, v.we, v.addr, v.din);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (!seen && (bus.mem_rd || bus.mem_we)) begin
        seen = 1'b1;
        check($sformatf("v%0d cmd_cycle", idx), 32'(c), 32'd1);
        check($sformatf("v%0d mem_addr", idx), 32'(bus.mem_addr), 32'(v.addr));
        check($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.we));
        if (v.we) check($sformatf("v%0d mem_din", idx), 32'(bus.mem_din), 32'(v.din));
      end
      if (acks() != 4'b0) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc = c;
          check($sformatf("v%0d ack_port", idx), 32'(ack_of(v.port)), 32'd1);
          check($sformatf("v%0d owner", idx), 32'(bus.owner), 32'(v.port));
          check($sformatf("v%0d rd_data", idx), 32'(bus.rd_data), 32'(v.exp_rd));
          drive_port(v.port, 1'b0, 1'b0, '0, 8'h00);
        end
      end
    end
    check($sformatf("v%0d ack_cycle", idx), 32'(ack_cyc), 32'(v.exp_ack_cyc));
    check($sformatf("v%0d ack_count", idx), 32'(n_ack), 32'd1);
  endtask

  // Reference model: transaction-level view scored by priority class
  task automatic run_random(input int n_cycles);
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    int                m_own  = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [7:0]        m_din  = 8'h00;
    logic              m_we   = 1'b0;
    logic [7:0]        m_rd   = 8'h00;
    logic              m_rr   = 1'b0;
    int                waits [2];
    logic              pend [4];
    int                prob [4];
    int                sc [4];
    int                best;
    logic [3:0]        exp_ack;
    logic [1:0]        exp_cmd;
    waits = '{0, 0};
    pend  = '{1'b0, 1'b0, 1'b0, 1'b0};
    prob  = '{3, 60, 30, 30};
    rand_mem  = 1'b1;
    mem_lat   = $urandom_range(0, 3);
    next_dout = 8'($urandom);
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      tick();
      exp_ack = m_done ? 4'(1 << m_own) : 4'b0;
      exp_cmd = m_busy ? (m_we ? 2'b10 : 2'b01) : 2'b00;
      check("rnd acks", 32'(acks()), 32'(exp_ack));
      check("rnd mem_cmd", 32'({bus.mem_we, bus.mem_rd}), 32'(exp_cmd));
      if (m_busy) begin
        check("rnd mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (m_we) check("rnd mem_din", 32'(bus.mem_din), 32'(m_din));
      end
      check("rnd owner", 32'(bus.owner), 32'(m_own));
      check("rnd rd_data", 32'(bus.rd_data), 32'(m_rd));

      for (int p = 0; p < 4; p++) begin
        if (ack_of(2'(p))) begin
          pend[p] = 1'b0;
          drive_port(2'(p), 1'b0, 1'b0, '0, 8'h00);
        end else if (!pend[p] && ($urandom_range(0, 99) < prob[p])) begin
          pend[p] = 1'b1;
          drive_port(2'(p), 1'b1, 1'($urandom), ADDR_W'($urandom), 8'($urandom));
        end
      end

      if (m_done) begin
        m_done = 1'b0;
      end else if (m_busy) begin
        if (bus.mem_ready) begin
          if (!m_we) m_rd = bus.mem_dout;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.dma_req || bus.cpu_req || bus.tape_req || bus.fdd_req) begin
        sc[0] = bus.dma_req ? 4 : 0;
        sc[1] = bus.cpu_req ? 2 : 0;
        sc[2] = bus.tape_req ? ((waits[0] >= MAX_WAIT) ? 3 : 1) : 0;
        sc[3] = bus.fdd_req ? ((waits[1] >= MAX_WAIT) ? 3 : 1) : 0;
        best = 0;
        for (int p = 1; p < 4; p++) if (sc[p] > sc[best]) best = p;
        if (best >= 2 && sc[2] == sc[3]) best = m_rr ? 3 : 2;
        case (best)
          0: begin m_addr = bus.dma_addr;  m_we = bus.dma_we; m_din = bus.dma_din; end
          1: begin m_addr = bus.cpu_addr;  m_we = bus.cpu_we; m_din = bus.cpu_din; end
          2: begin m_addr = bus.tape_addr; m_we = 1'b0;       m_din = 8'h00; end
          default: begin m_addr = bus.fdd_addr; m_we = 1'b0; m_din = 8'h00; end
        endcase
        if (best >= 2) begin
          m_rr = !m_rr;
          waits[best-2] = 0;
        end
        if (best == 1) begin
          if (bus.tape_req && waits[0] < MAX_WAIT) waits[0]++;
          if (bus.fdd_req && waits[1] < MAX_WAIT) waits[1]++;
        end
        m_own  = best;
        m_busy = 1'b1;
      end
      if (!bus.tape_req) waits[0] = 0;
      if (!bus.fdd_req) waits[1] = 0;
    end
    rand_mem = 1'b0;
    clear_inputs();
    repeat (6) tick();
  endtask

  initial begin
    int ack_c [4];
    int own [10];
    int n_ack;
    int n_rd;
    int d_ack;
    int c_ack;

    vecs[0] = '{port: 2'd1, we: 1'b0, addr: 25'h0005ABC,  din: 8'h00, lat: 1, dout: 8'h3C, exp_ack_cyc: 3, exp_rd: 8'h3C};
    vecs[1] = '{port: 2'd0, we: 1'b1, addr: 25'h0181FFF,  din: 8'hA5, lat: 0, dout: 8'h11, exp_ack_cyc: 2, exp_rd: 8'h3C};
    vecs[2] = '{port: 2'd2, we: 1'b0, addr: 25'h1000000,  din: 8'h00, lat: 0, dout: 8'h5A, exp_ack_cyc: 2, exp_rd: 8'h5A};
    vecs[3] = '{port: 2'd3, we: 1'b0, addr: 25'h1FFFFFF,  din: 8'h00, lat: 2, dout: 8'hC3, exp_ack_cyc: 4, exp_rd: 8'hC3};
    vecs[4] = '{port: 2'd1, we: 1'b1, addr: 25'h0000000,  din: 8'h00, lat: 3, dout: 8'h22, exp_ack_cyc: 5, exp_rd: 8'hC3};
    vecs[5] = '{port: 2'd0, we: 1'b0, addr: 25'h0AAAAAA,  din: 8'h00, lat: 0, dout: 8'h00, exp_ack_cyc: 2, exp_rd: 8'h00};

    bus.mem_ready = 1'b0;
    bus.mem_dout  = 8'h00;
    clear_inputs();
    do_reset(3);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // DMA write and CPU read raised together: DMA first, CPU next
    mem_lat = 0; next_dout = 8'h77; d_ack = -1; c_ack = -1;
    drive_port(2'd0, 1'b1, 1'b1, 25'h0181FFF, 8'hA5);
    drive_port(2'd1, 1'b1, 1'b0, 25'h0123456, 8'h00);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        check("col dma mem_we", 32'({bus.mem_we, bus.mem_rd}), 32'b10);
        check("col dma mem_din", 32'(bus.mem_din), 32'hA5);
        check("col dma mem_addr", 32'(bus.mem_addr), 32'h0181FFF);
      end
      if (c == 4) check("col cpu mem_addr", 32'(bus.mem_addr), 32'h0123456);
      if (bus.dma_ack && d_ack < 0) begin
        d_ack = c;
        check("col dma rd_data kept", 32'(bus.rd_data), 32'h00);
        drive_port(2'd0, 1'b0, 1'b0, '0, 8'h00);
      end
      if (bus.cpu_ack && c_ack < 0) begin
        c_ack = c;
        check("col cpu rd_data", 32'(bus.rd_data), 32'h77);
        check("col cpu owner", 32'(bus.owner), 32'd1);
        drive_port(2'd1, 1'b0, 1'b0, '0, 8'h00);
      end
    end
    check("col dma ack_cycle", 32'(d_ack), 32'd2);
    check("col cpu ack_cycle", 32'(c_ack), 32'd5);

    // Tape and FDD held together alternate starting with tape
    do_reset(2);
    mem_lat = 0; next_dout = 8'h10; n_ack = 0;
    drive_port(2'd2, 1'b1, 1'b0, 25'h0000100, 8'h00);
    drive_port(2'd3, 1'b1, 1'b0, 25'h0000200, 8'h00);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if ((bus.tape_ack || bus.fdd_ack) && n_ack < 4) begin
        ack_c[n_ack] = c;
        own[n_ack]   = bus.tape_ack ? 2 : 3;
        n_ack++;
        if (n_ack == 4) clear_inputs();
      end
    end
    check("rr ack_count", 32'(n_ack), 32'd4);
    for (int i = 0; i < n_ack; i++) begin
      check($sformatf("rr grant%0d owner", i), 32'(own[i]), 32'((i % 2 == 0) ? 2 : 3));
      check($sformatf("rr grant%0d cycle", i), 32'(ack_c[i]), 32'(2 + 3 * i));
    end

    // CPU held continuously against tape: tape promoted after MAX_WAIT CPU wins
    do_reset(2);
    mem_lat = 0; n_ack = 0;
    drive_port(2'd1, 1'b1, 1'b0, 25'h0000300, 8'h00);
    drive_port(2'd2, 1'b1, 1'b0, 25'h0000400, 8'h00);
    for (int c = 1; c <= 60 && n_ack < 10; c++) begin
      tick();
      if (acks() != 4'b0) begin
        own[n_ack] = bus.tape_ack ? 2 : (bus.cpu_ack ? 1 : 0);
        if (bus.tape_ack) drive_port(2'd2, 1'b0, 1'b0, '0, 8'h00);
        n_ack++;
      end
    end
    clear_inputs();
    check("starve ack_count", 32'(n_ack), 32'd10);
    for (int i = 0; i < n_ack; i++)
      check($sformatf("starve grant%0d owner", i), 32'(own[i]), 32'((i == MAX_WAIT) ? 2 : 1));
    repeat (4) tick();

    // Reset pulse during ACCESS aborts the access without an ack
    mem_lat = 1000; next_dout = 8'h99; n_ack = 0; c_ack = -1;
    drive_port(2'd1, 1'b1, 1'b0, 25'h0000555, 8'h00);
    tick();
    check("rst_mid mem_rd c1", 32'(bus.mem_rd), 32'd1);
    tick();
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    check("rst_mid mem_rd after", 32'(bus.mem_rd), 32'd0);
    check("rst_mid no ack", 32'(acks()), 32'h0);
    check("rst_mid owner", 32'(bus.owner), 32'd0);
    mem_lat = 0;
    for (int c = 4; c <= 15; c++) begin
      tick();
      if (bus.cpu_ack) begin
        n_ack++;
        if (c_ack < 0) begin
          c_ack = c;
          check("rst_mid rd_data", 32'(bus.rd_data), 32'h99);
          drive_port(2'd1, 1'b0, 1'b0, '0, 8'h00);
        end
      end
    end
    check("rst_mid rearb ack_cycle", 32'(c_ack), 32'd5);
    check("rst_mid ack_count", 32'(n_ack), 32'd1);

    // Slow memory; CPU drops its request mid-access and scrambles its address
    mem_lat = 10; next_dout = 8'h4D; n_ack = 0; n_rd = 0;
    drive_port(2'd1, 1'b1, 1'b0, 25'h00ABCDE, 8'h00);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 3) drive_port(2'd1, 1'b0, 1'b0, 25'h1FFFFFF, 8'h00);
      if (bus.mem_rd) begin
        n_rd++;
        check("slow mem_addr", 32'(bus.mem_addr), 32'h00ABCDE);
      end
      if (bus.cpu_ack) begin
        n_ack++;
        check("slow rd_data", 32'(bus.rd_data), 32'h4D);
      end
    end
    check("slow mem_rd cycles", 32'(n_rd), 32'd11);
    check("slow ack_count", 32'(n_ack), 32'd1);

    do_reset(2);
    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
